// File: rtl/instruction_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word requests to instruction
// memory, and queues (pc, instr) pairs in a 2-entry FIFO that feeds the
// fetch/decode register. A redirect flushes the FIFO and drops any response
// still in flight.
//
// Handshake: a request transfers on a cycle where imem_req && imem_gnt;
// imem_req/imem_addr stay stable while imem_gnt is low unless a redirect
// intervenes. Each granted request is answered by exactly one imem_rvalid
// cycle, at the earliest the cycle after the grant. The fetch/decode side
// consumes the FIFO head on any cycle where fd_valid && !stall.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        fd_valid,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_instruction,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // nothing outstanding
    S_BUSY = 2'd1,  // one request outstanding, its data will be kept
    S_DROP = 2'd2   // one request outstanding, its data will be discarded
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_pending_pc;
  logic [31:0] r_fifo_pc    [2];
  logic [31:0] r_fifo_instr [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_occ;

  logic        w_pop;
  logic        w_push;
  logic        w_req;
  logic        w_grant;
  logic [2:0]  w_credit;

  assign w_pop   = (r_occ != 2'd0) && !stall;
  assign w_grant = w_req && imem_gnt;
  // Work already committed once this cycle's pop is accounted for.
  assign w_credit = {1'b0, r_occ} + {2'b00, (r_state != S_IDLE)} - {2'b00, w_pop};

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state logic; redirect turns an unanswered request into a drop.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_grant) w_state_nxt = S_BUSY;
      S_BUSY: begin
        if (redirect)         w_state_nxt = imem_rvalid ? S_IDLE : S_DROP;
        else if (imem_rvalid) w_state_nxt = w_grant ? S_BUSY : S_IDLE;
      end
      S_DROP: if (imem_rvalid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: request issue (credit-limited) and response push.
  always_comb begin
    w_req  = !rst && !redirect &&
             (r_state == S_IDLE || (r_state == S_BUSY && imem_rvalid)) &&
             (w_credit < 3'd2);
    w_push = (r_state == S_BUSY) && imem_rvalid && !redirect;
  end

  // Program counter and the address of the request currently outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc   <= RESET_PC;
      r_pending_pc <= RESET_PC;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
    end else if (w_grant) begin
      r_pending_pc <= r_fetch_pc;
      r_fetch_pc   <= r_fetch_pc + 32'd4;
    end
  end

  // Output FIFO: push responses, pop on unstalled consume, flush on redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ           <= 2'd0;
      r_rd_ptr        <= 1'b0;
      r_wr_ptr        <= 1'b0;
      r_fifo_pc[0]    <= 32'h0;
      r_fifo_pc[1]    <= 32'h0;
      r_fifo_instr[0] <= 32'h0;
      r_fifo_instr[1] <= 32'h0;
    end else if (redirect) begin
      r_occ    <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo_pc[r_wr_ptr]    <= r_pending_pc;
        r_fifo_instr[r_wr_ptr] <= imem_rdata;
        r_wr_ptr               <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign imem_req       = w_req;
  assign imem_addr      = r_fetch_pc;
  assign fd_valid       = (r_occ != 2'd0);
  assign fd_pc          = fd_valid ? r_fifo_pc[r_rd_ptr] : 32'h0;
  assign fd_instruction = fd_valid ? r_fifo_instr[r_rd_ptr] : NOP_INSTR;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit. The memory model answers with
// data 0xC0DE_<addr[15:0]>, either automatically one cycle after each grant
// or under direct control of the sequence.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        fd_valid;
  logic [31:0] fd_pc;
  logic [31:0] fd_instruction;
  logic [1:0]  dbg_state;

  int n_total = 0;
  int n_bad   = 0;
  bit auto_rsp = 1'b1;

  instruction_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .fd_valid(fd_valid), .fd_pc(fd_pc), .fd_instruction(fd_instruction),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, got=running exp=finished");
    $fatal(1);
  end

  function automatic logic [31:0] mk(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; in auto mode the memory answers the grant seen before the edge.
  task automatic tick();
    logic        g;
    logic [31:0] a;
    g = imem_req && imem_gnt;
    a = imem_addr;
    @(posedge clk);
    #1;
    if (auto_rsp) begin
      imem_rvalid = g;
      imem_rdata  = g ? mk(a) : 32'h0;
    end
  endtask

  task automatic fd_chk(input string tag, input logic [31:0] pc);
    check({tag, "_v"},   {31'b0, fd_valid}, 32'd1);
    check({tag, "_pc"},  fd_pc, pc);
    check({tag, "_ins"}, fd_instruction, mk(pc));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    @(posedge clk); #1;
    // reset state
    check("rst_fdv",  {31'b0, fd_valid}, 32'd0);
    check("rst_fdpc", fd_pc, 32'h0);
    check("rst_ins",  fd_instruction, 32'h0000_0013);
    check("rst_req",  {31'b0, imem_req}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    // zero-wait stream
    check("c0_req", {31'b0, imem_req}, 32'd1);
    check("c0_addr", imem_addr, 32'h0);
    tick(); #1;
    check("c1_addr", imem_addr, 32'h4);
    check("c1_fdv", {31'b0, fd_valid}, 32'd0);
    tick(); #1;
    fd_chk("c2", 32'h0);
    check("c2_addr", imem_addr, 32'h8);
    tick(); #1;
    fd_chk("c3", 32'h4);
    check("c3_addr", imem_addr, 32'hC);
    tick();
    // stall for 3 cycles with head at 0x8
    stall = 1'b1; #1;
    fd_chk("s0", 32'h8);
    check("s0_req", {31'b0, imem_req}, 32'd0);
    tick(); #1;
    fd_chk("s1", 32'h8);
    check("s1_req", {31'b0, imem_req}, 32'd0);
    tick(); #1;
    fd_chk("s2", 32'h8);
    check("s2_req", {31'b0, imem_req}, 32'd0);
    tick();
    stall = 1'b0; #1;
    fd_chk("r0", 32'h8);
    check("r0_req", {31'b0, imem_req}, 32'd1);
    check("r0_addr", imem_addr, 32'h10);
    tick(); #1;
    fd_chk("r1", 32'hC);
    check("r1_addr", imem_addr, 32'h14);
    tick(); #1;
    fd_chk("r2", 32'h10);
    auto_rsp = 1'b0;
    tick();
    // redirect while BUSY, response for 0x18 arrives one cycle later
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b1; redirect_pc = 32'h100; #1;
    fd_chk("d0", 32'h14);
    check("d0_req", {31'b0, imem_req}, 32'd0);
    tick();
    redirect = 1'b0; imem_rvalid = 1'b1; imem_rdata = mk(32'h18); #1;
    check("d1_fdv", {31'b0, fd_valid}, 32'd0);
    check("d1_fdpc", fd_pc, 32'h0);
    check("d1_ins", fd_instruction, 32'h0000_0013);
    check("d1_state", {30'b0, dbg_state}, 32'd2);
    check("d1_req", {31'b0, imem_req}, 32'd0);
    tick();
    imem_rvalid = 1'b0; imem_rdata = 32'h0; #1;
    check("d2_fdv", {31'b0, fd_valid}, 32'd0);
    check("d2_req", {31'b0, imem_req}, 32'd1);
    check("d2_addr", imem_addr, 32'h100);
    auto_rsp = 1'b1;
    tick(); #1;
    check("d3_addr", imem_addr, 32'h104);
    check("d3_fdv", {31'b0, fd_valid}, 32'd0);
    tick();
    // grant withheld for 4 cycles
    imem_gnt = 1'b0; #1;
    fd_chk("g0", 32'h100);
    check("g0_addr", imem_addr, 32'h108);
    for (int i = 1; i < 4; i++) begin
      tick(); #1;
      check($sformatf("g%0d_req", i), {31'b0, imem_req}, 32'd1);
      check($sformatf("g%0d_addr", i), imem_addr, 32'h108);
      if (i == 1) fd_chk("g1", 32'h104);
    end
    tick();
    imem_gnt = 1'b1; #1;
    check("g4_req", {31'b0, imem_req}, 32'd1);
    check("g4_addr", imem_addr, 32'h108);
    tick(); #1;
    check("g5_addr", imem_addr, 32'h10C);
    tick(); #1;
    fd_chk("g6", 32'h108);
    check("g6_addr", imem_addr, 32'h110);
    auto_rsp = 1'b0;
    tick();
    // async reset with the 0x110 request outstanding
    imem_rvalid = 1'b0; imem_rdata = 32'h0; imem_gnt = 1'b0; #1;
    fd_chk("a0", 32'h10C);
    rst = 1'b1; #1;
    check("a1_fdv", {31'b0, fd_valid}, 32'd0);
    check("a1_req", {31'b0, imem_req}, 32'd0);
    check("a1_ins", fd_instruction, 32'h0000_0013);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = mk(32'h110); #1;
    check("a2_req", {31'b0, imem_req}, 32'd1);
    check("a2_addr", imem_addr, 32'h0);
    tick();
    imem_rvalid = 1'b0; imem_rdata = 32'h0; #1;
    check("a3_fdv", {31'b0, fd_valid}, 32'd0);
    check("a3_state", {30'b0, dbg_state}, 32'd0);
    check("a3_addr", imem_addr, 32'h0);
    imem_gnt = 1'b1; auto_rsp = 1'b1;
    tick(); #1;
    check("a4_addr", imem_addr, 32'h4);
    tick(); #1;
    fd_chk("a5", 32'h0);
    // redirect to the top of the address space (BUSY with rvalid: data dropped)
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    check("w0_req", {31'b0, imem_req}, 32'd0);
    tick();
    redirect = 1'b0; #1;
    check("w1_fdv", {31'b0, fd_valid}, 32'd0);
    check("w1_addr", imem_addr, 32'hFFFF_FFFC);
    tick(); #1;
    check("w2_addr", imem_addr, 32'h0);
    tick(); #1;
    fd_chk("w3", 32'hFFFF_FFFC);
    check("w3_addr", imem_addr, 32'h4);
    tick(); #1;
    fd_chk("w4", 32'h0);
    tick(); #1;
    fd_chk("w5", 32'h4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
